// File: rtl/axil_regfile_slave_if.sv
// AXI4-Lite bus bundle for axil_regfile_slave: the five channels without clock/reset.
interface axil_regfile_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7
);
  logic                  AWVALID;
  logic                  AWREADY;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  WVALID;
  logic                  WREADY;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  BVALID;
  logic                  BREADY;
  logic [1:0]            BRESP;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_W-1:0]     ARADDR;
  logic [2:0]            ARPROT;
  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;

  modport master (
    output AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    input  AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );

  modport slave (
    input  AWVALID, AWADDR, AWPROT, WVALID, WDATA, WSTRB, BREADY,
           ARVALID, ARADDR, ARPROT, RREADY,
    output AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP
  );
endinterface

// File: rtl/axil_regfile_slave.sv
// Parametrised AXI4-Lite register file with independent AW/W buffering and held responses.
// Optional macro AXIL_REGFILE_SLVERR_EN: out-of-range accesses answer SLVERR instead of OKAY.
module axil_regfile_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_REGS           = 32
) (
  input  logic                                   S_AXI_ACLK,
  input  logic                                   S_AXI_ARESET,
  axil_regfile_slave_if.slave                    S_AXI,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]                    wr_pulse_o
);
  localparam int DW      = C_S_AXI_DATA_WIDTH;
  localparam int AW      = C_S_AXI_ADDR_WIDTH;
  localparam int SW      = DW / 8;
  localparam int ADDRLSB = $clog2(SW);
  localparam int IW      = AW - ADDRLSB;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  function automatic logic [1:0] resp_for(input logic [IW-1:0] idx);
    return in_range(idx) ? RESP_OKAY : RESP_OOR;
  endfunction

  // Out-of-range indices match no register and therefore read as zero.
  function automatic logic [DW-1:0] reg_read(input logic [NUM_REGS*DW-1:0] flat,
                                             input logic [IW-1:0] idx);
    logic [DW-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (32'(idx) == 32'(i)) v = flat[i*DW +: DW];
    return v;
  endfunction

  logic                   awf, wf, awready_q, wready_q, bvalid_q;
  logic [1:0]             bresp_q;
  logic [IW-1:0]          aw_idx_q;
  logic [DW-1:0]          wdata_q;
  logic [SW-1:0]          wstrb_q;
  logic [NUM_REGS*DW-1:0] regs_q;
  logic [NUM_REGS-1:0]    wr_pulse_q;
  logic                   aw_hs, w_hs, commit;

  assign aw_hs  = S_AXI.AWVALID && awready_q;
  assign w_hs   = S_AXI.WVALID && wready_q;
  assign commit = awf && wf && (!bvalid_q || S_AXI.BREADY);

  // Write stage: capture AW/W payloads into their one-entry buffers
  always_ff @(posedge S_AXI_ACLK) begin
    if (aw_hs) aw_idx_q <= S_AXI.AWADDR[AW-1:ADDRLSB];
    if (w_hs) begin
      wdata_q <= S_AXI.WDATA;
      wstrb_q <= S_AXI.WSTRB;
    end
  end

  // Write stage: commit buffered pair, update register, issue held B response
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      awf        <= 1'b0;
      wf         <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      regs_q     <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (commit) begin
        awf       <= 1'b0;
        wf        <= 1'b0;
        awready_q <= 1'b1;
        wready_q  <= 1'b1;
        bvalid_q  <= 1'b1;
        bresp_q   <= resp_for(aw_idx_q);
        for (int i = 0; i < NUM_REGS; i++) begin
          if (32'(aw_idx_q) == 32'(i)) begin
            wr_pulse_q[i] <= 1'b1;
            for (int b = 0; b < SW; b++)
              if (wstrb_q[b]) regs_q[i*DW + b*8 +: 8] <= wdata_q[b*8 +: 8];
          end
        end
      end else begin
        // Buffers can only fill here; a full buffer already holds READY low.
        if (bvalid_q && S_AXI.BREADY) bvalid_q <= 1'b0;
        awf       <= awf || aw_hs;
        wf        <= wf || w_hs;
        awready_q <= !(awf || aw_hs);
        wready_q  <= !(wf || w_hs);
      end
    end
  end

  logic          ar_en, rvalid_q, ar_hs;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;
  logic [IW-1:0] ar_idx;

  assign ar_idx = S_AXI.ARADDR[AW-1:ADDRLSB];
  assign ar_hs  = S_AXI.ARVALID && S_AXI.ARREADY;
  assign S_AXI.ARREADY = ar_en && (!rvalid_q || S_AXI.RREADY);

  // Read stage: sample register contents before any same-edge write lands
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      ar_en    <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      ar_en <= 1'b1;
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= reg_read(regs_q, ar_idx);
        rresp_q  <= resp_for(ar_idx);
      end else if (S_AXI.RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  assign S_AXI.AWREADY = awready_q;
  assign S_AXI.WREADY  = wready_q;
  assign S_AXI.BVALID  = bvalid_q;
  assign S_AXI.BRESP   = bresp_q;
  assign S_AXI.RVALID  = rvalid_q;
  assign S_AXI.RDATA   = rdata_q;
  assign S_AXI.RRESP   = rresp_q;
  assign regs_o        = regs_q;
  assign wr_pulse_o    = wr_pulse_q;

  logic unused_ok;
  assign unused_ok = ^{S_AXI.AWPROT, S_AXI.ARPROT,
                       S_AXI.AWADDR[ADDRLSB-1:0], S_AXI.ARADDR[ADDRLSB-1:0]};
endmodule

// File: tb/tb_axil_regfile_slave.sv
// Scoreboard bench for axil_regfile_slave: directed AXI-Lite traffic, monitor checks B/R beats.
module tb_axil_regfile_slave;
  localparam int DW = 32;
  localparam int AW = 7;
  localparam int NR = 20;
`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axil_regfile_slave_if #(.DATA_W(DW), .ADDR_W(AW)) axi ();
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0]    wr_pulse;

  axil_regfile_slave #(
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW),
    .NUM_REGS(NR)
  ) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .S_AXI       (axi),
    .regs_o      (regs_flat),
    .wr_pulse_o  (wr_pulse)
  );

  int checks = 0;
  int failures = 0;
  logic [1:0] exp_b[$];
  rexp_t      exp_r[$];
  int b_beats = 0;
  int pulse_total = 0;
  int pulse_cnt[NR];
  logic b_hold = 1'b0, r_hold = 1'b0;
  logic [1:0]  b_prev;
  logic [33:0] r_prev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] getreg(input int i);
    return regs_flat[i*32 +: 32];
  endfunction

  // Monitor: pop expectations on every accepted B/R beat, check held responses
  always @(negedge clk) begin
    rexp_t re;
    if (rst) begin
      b_hold = 1'b0;
      r_hold = 1'b0;
    end else begin
      if (axi.BVALID && b_hold) chk("b_stable", 64'(axi.BRESP), 64'(b_prev));
      if (axi.BVALID && axi.BREADY) begin
        b_beats++;
        chk("b_expected", 64'(exp_b.size() > 0), 64'd1);
        if (exp_b.size() > 0) chk("bresp", 64'(axi.BRESP), 64'(exp_b.pop_front()));
      end
      b_hold = axi.BVALID && !axi.BREADY;
      b_prev = axi.BRESP;

      if (axi.RVALID && r_hold) chk("r_stable", 64'({axi.RRESP, axi.RDATA}), 64'(r_prev));
      if (axi.RVALID && axi.RREADY) begin
        chk("r_expected", 64'(exp_r.size() > 0), 64'd1);
        if (exp_r.size() > 0) begin
          re = exp_r.pop_front();
          chk("rdata", 64'(axi.RDATA), 64'(re.d));
          chk("rresp", 64'(axi.RRESP), 64'(re.r));
        end
      end
      r_hold = axi.RVALID && !axi.RREADY;
      r_prev = {axi.RRESP, axi.RDATA};

      if (wr_pulse != '0) begin
        chk("pulse_onehot", 64'($onehot(wr_pulse)), 64'd1);
        pulse_total++;
        for (int i = 0; i < NR; i++) if (wr_pulse[i]) pulse_cnt[i]++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [6:0] a);
    int n = 0;
    axi.AWADDR = a;
    axi.AWVALID = 1'b1;
    @(negedge clk);
    while (!axi.AWREADY && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", 64'(axi.AWREADY), 64'd1);
    @(posedge clk);
    #1;
    axi.AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    axi.WDATA = d;
    axi.WSTRB = s;
    axi.WVALID = 1'b1;
    @(negedge clk);
    while (!axi.WREADY && n < 50) begin @(negedge clk); n++; end
    chk("w_accept", 64'(axi.WREADY), 64'd1);
    @(posedge clk);
    #1;
    axi.WVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [6:0] a);
    int n = 0;
    axi.ARADDR = a;
    axi.ARVALID = 1'b1;
    @(negedge clk);
    while (!axi.ARREADY && n < 50) begin @(negedge clk); n++; end
    chk("ar_accept", 64'(axi.ARREADY), 64'd1);
    @(posedge clk);
    #1;
    axi.ARVALID = 1'b0;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] resp);
    exp_b.push_back(resp);
    fork
      aw_send(a);
      w_send(d, s);
    join
  endtask

  task automatic do_read(input logic [6:0] a, input logic [31:0] d, input logic [1:0] resp);
    rexp_t e;
    e.d = d;
    e.r = resp;
    exp_r.push_back(e);
    ar_send(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 100) begin tick(); n++; end
    chk("drain", 64'(exp_b.size() + exp_r.size()), 64'd0);
  endtask

  initial begin
    logic [NR*DW-1:0] snap;
    logic [31:0] vals[4];
    int base16, bb, pt;
    rexp_t e;

    axi.AWVALID = 0; axi.AWADDR = '0; axi.AWPROT = '0;
    axi.WVALID = 0;  axi.WDATA = '0;  axi.WSTRB = '0;
    axi.ARVALID = 0; axi.ARADDR = '0; axi.ARPROT = '0;
    axi.BREADY = 1;  axi.RREADY = 1;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_awready", 64'(axi.AWREADY), 0);
    chk("rst_wready", 64'(axi.WREADY), 0);
    chk("rst_arready", 64'(axi.ARREADY), 0);
    chk("rst_bvalid", 64'(axi.BVALID), 0);
    chk("rst_rvalid", 64'(axi.RVALID), 0);
    chk("rst_rdata", 64'(axi.RDATA), 0);
    chk("rst_regs", 64'(|regs_flat), 0);
    chk("rst_pulse", 64'(wr_pulse), 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("post_rst_awready", 64'(axi.AWREADY), 1);
    chk("post_rst_wready", 64'(axi.WREADY), 1);
    chk("post_rst_arready", 64'(axi.ARREADY), 1);

    // Single write with top-byte strobe, latency and pulse
    tick();
    do_write(7'h40, 32'h8000_0000, 4'b1000, 2'b00);
    @(negedge clk);
    chk("t1_bvalid_early", 64'(axi.BVALID), 0);
    @(negedge clk);
    chk("t1_bvalid", 64'(axi.BVALID), 1);
    chk("t1_pulse", 64'(wr_pulse), 64'h1_0000);
    chk("t1_reg16", 64'(getreg(16)), 64'h8000_0000);
    @(negedge clk);
    chk("t1_pulse_clear", 64'(wr_pulse), 0);
    tick();
    do_read(7'h40, 32'h8000_0000, 2'b00);
    wait_idle();

    // Held AW/W/AR for 4 cycles under B backpressure
    tick();
    base16 = pulse_cnt[16];
    bb = b_beats;
    axi.BREADY = 1'b0;
    e.r = 2'b00;
    e.d = 32'h8000_0000; exp_r.push_back(e); exp_r.push_back(e);
    e.d = 32'h0000_00A5; exp_r.push_back(e); exp_r.push_back(e);
    exp_b.push_back(2'b00); exp_b.push_back(2'b00);
    axi.AWADDR = 7'h40; axi.WDATA = 32'h0000_00A5; axi.WSTRB = 4'hF; axi.ARADDR = 7'h40;
    axi.AWVALID = 1'b1; axi.WVALID = 1'b1; axi.ARVALID = 1'b1;
    repeat (4) tick();
    axi.AWVALID = 1'b0; axi.WVALID = 1'b0; axi.ARVALID = 1'b0;
    @(negedge clk);
    chk("t2_awready_low", 64'(axi.AWREADY), 0);
    chk("t2_wready_low", 64'(axi.WREADY), 0);
    chk("t2_bvalid_held", 64'(axi.BVALID), 1);
    chk("t2_one_commit", 64'(pulse_cnt[16] - base16), 1);
    chk("t2_reg16", 64'(getreg(16)), 64'h0000_00A5);
    repeat (3) tick();
    @(negedge clk);
    chk("t2_awready_still_low", 64'(axi.AWREADY), 0);
    chk("t2_bvalid_still", 64'(axi.BVALID), 1);
    chk("t2_no_beats_yet", 64'(b_beats - bb), 0);
    tick();
    axi.BREADY = 1'b1;
    wait_idle();
    repeat (2) tick();
    chk("t2_two_beats", 64'(b_beats - bb), 2);
    chk("t2_two_commits", 64'(pulse_cnt[16] - base16), 2);

    // AW early, W three cycles later, partial strobe over preloaded value
    tick();
    do_write(7'h08, 32'h1234_5678, 4'hF, 2'b00);
    wait_idle();
    tick();
    exp_b.push_back(2'b00);
    aw_send(7'h08);
    @(negedge clk);
    chk("t3_awready_buffered", 64'(axi.AWREADY), 0);
    chk("t3_wready_open", 64'(axi.WREADY), 1);
    chk("t3_no_bvalid", 64'(axi.BVALID), 0);
    tick();
    tick();
    w_send(32'hAAAA_5555, 4'b0011);
    @(negedge clk);
    chk("t3_bvalid_early", 64'(axi.BVALID), 0);
    @(negedge clk);
    chk("t3_bvalid", 64'(axi.BVALID), 1);
    chk("t3_pulse", 64'(wr_pulse), 64'h4);
    chk("t3_reg2", 64'(getreg(2)), 64'h1234_5555);
    wait_idle();

    // Out-of-range index
    tick();
    snap = regs_flat;
    pt = pulse_total;
    do_write(7'h7C, 32'hFFFF_FFFF, 4'hF, OOR_RESP);
    wait_idle();
    chk("t4_regs_unchanged", 64'(regs_flat == snap), 1);
    chk("t4_no_pulse", 64'(pulse_total - pt), 0);
    do_read(7'h7C, 32'h0, OOR_RESP);
    do_read(7'h60, 32'h0, OOR_RESP);
    wait_idle();

    // Back-to-back reads with RREADY 1,0,1,1
    vals[0] = 32'h0A0A_0000; vals[1] = 32'h1B1B_0001;
    vals[2] = 32'h2C2C_0002; vals[3] = 32'h3D3D_0003;
    for (int i = 0; i < 4; i++) do_write(7'(i*4), vals[i], 4'hF, 2'b00);
    wait_idle();
    tick();
    for (int i = 0; i < 4; i++) begin
      e.d = vals[i];
      e.r = 2'b00;
      exp_r.push_back(e);
    end
    fork
      for (int i = 0; i < 4; i++) ar_send(7'(i*4));
      begin
        axi.RREADY = 1'b1; tick();
        axi.RREADY = 1'b0; tick();
        axi.RREADY = 1'b1;
      end
    join
    wait_idle();

    // Reset with AW buffered and BVALID pending
    tick();
    axi.BREADY = 1'b0;
    do_write(7'h00, 32'h5555_AAAA, 4'hF, 2'b00);
    aw_send(7'h04);
    @(negedge clk);
    chk("t6_bvalid_pending", 64'(axi.BVALID), 1);
    chk("t6_aw_buffered", 64'(axi.AWREADY), 0);
    tick();
    rst = 1'b1;
    exp_b.delete();
    exp_r.delete();
    tick();
    @(negedge clk);
    chk("t6_bvalid", 64'(axi.BVALID), 0);
    chk("t6_rvalid", 64'(axi.RVALID), 0);
    chk("t6_awready", 64'(axi.AWREADY), 0);
    chk("t6_regs", 64'(|regs_flat), 0);
    tick();
    rst = 1'b0;
    axi.BREADY = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_ready_again", 64'(axi.AWREADY && axi.WREADY && axi.ARREADY), 1);
    tick();
    do_write(7'h0C, 32'hCAFE_F00D, 4'hF, 2'b00);
    wait_idle();
    do_read(7'h0C, 32'hCAFE_F00D, 2'b00);
    wait_idle();
    chk("t6_reg3", 64'(getreg(3)), 64'hCAFE_F00D);
    chk("t6_reg1_clean", 64'(getreg(1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
